// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined) fed by a DEPTH-entry byte FIFO.
// Latency: byte pushed into an empty FIFO at edge T is popped at T+1; tx start bit begins at T+2.
// Backpressure: din_ready drops while the FIFO holds DEPTH bytes; pushes while full are ignored.

// Generic synchronous FIFO with registered occupancy count.
// Latency: written data is readable on rdat the cycle after the push.
// Backpressure: push ignored while full; pop ignored while empty.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdat,
  input  logic         pop,
  output logic [W-1:0] rdat,
  output logic [AW:0]  cnt,
  output logic         full
);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == FULL_CNT);
  assign push_ok = push && !full;
  assign pop_ok  = pop && (cnt != '0);
  assign rdat    = mem[rd_ptr];

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdat;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 8,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        tx,
  output logic        busy_flag,
  output logic [AW:0] fifo_cnt
);
  localparam int          BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    fifo_rdat;
  logic          fifo_full;
  logic          baud_last;
  logic          pop;

  assign din_ready = !fifo_full;
  assign baud_last = (baud == BAUD_LAST);

  // Pop from IDLE, or on the final stop-bit cycle so frames chain with no gap.
  // Decision uses the registered count, so a fresh byte is popped one cycle after its push.
  always_comb begin
    pop = 1'b0;
    if (fifo_cnt != '0) begin
      pop = (state == S_IDLE) || ((state == S_STOP) && baud_last);
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (8)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .push  (din_valid && din_ready),
    .wdat  (din),
    .pop   (pop),
    .rdat  (fifo_rdat),
    .cnt   (fifo_cnt),
    .full  (fifo_full)
  );

  // Frame sequencer; tx and busy_flag are registered from the current state, one cycle behind it.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      tx        <= 1'b1;
      busy_flag <= 1'b0;
    end else begin
      busy_flag <= (state != S_IDLE) || (fifo_cnt != '0);
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= fifo_rdat;
            baud  <= '0;
            state <= S_START;
          end
        end
        S_START: begin
          tx <= 1'b0;
          if (baud_last) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_DATA: begin
          tx <= shift[bit_idx];
          if (baud_last) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          tx <= ^shift;
          if (baud_last) begin
            baud  <= '0;
            state <= S_STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        S_STOP: begin
          tx <= 1'b1;
          if (baud_last) begin
            baud <= '0;
            if (pop) begin
              shift <= fifo_rdat;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          baud  <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: line frames are compared against a
// bit-list model of each byte, FIFO occupancy against an arithmetic push/pop model.
module tb_uart_tx_fifo;
  localparam int CPB   = 434;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic [7:0]    din;
  logic          din_valid;
  logic          din_ready;
  logic          tx;
  logic          busy_flag;
  logic [AW:0]   fifo_cnt;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH),
    .AW           (AW)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .tx        (tx),
    .busy_flag (busy_flag),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Line bits in time order (index 0 = start bit): start, 8 data LSB-first, [even parity], stop.
  function automatic logic [NB-1:0] model_frame(input logic [7:0] b);
    logic [NB-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = (($countones(b) % 2) == 1);
`endif
    return f;
  endfunction

  // Waits for a start bit, then samples every cycle of the frame.
  task automatic check_frame(input logic [7:0] b, input string name, input bit b2b);
    int            waited;
    logic [NB-1:0] got;
    logic [NB-1:0] exp;
    bit            stable;
    waited = 0;
    while (tx !== 1'b0 && waited < 3 * FRAME) begin
      @(negedge sys_clk);
      waited++;
    end
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL %s start: tx=%b after %0d cycles, required 0", name, tx, waited);
      return;
    end
    if (b2b) begin
      checks++;
      if (waited != 0) begin
        errors++;
        $display("FAIL %s gap: idle cycles=%0d, required 0", name, waited);
      end
    end
    got    = '0;
    stable = 1'b1;
    for (int i = 0; i < NB; i++) begin
      got[i] = tx;
      for (int j = 0; j < CPB; j++) begin
        if (tx !== got[i]) stable = 1'b0;
        @(negedge sys_clk);
      end
    end
    exp = model_frame(b);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s bits (start bit rightmost): got=%b required=%b", name, got, exp);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL %s bit_width: tx changed inside a bit period, required %0d stable cycles", name, CPB);
    end
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    din_valid = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din       = 8'h00;
    #20;
    rst_n = 1'b1;
    @(negedge sys_clk);
    checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
    checks++; if (busy_flag !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy_flag); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", din_ready); end
    checks++; if (fifo_cnt !== 4'd0)  begin errors++; $display("FAIL reset_cnt: got %0d required 0", fifo_cnt); end
  endtask

  task automatic test_single();
    din       = 8'h03;
    din_valid = 1'b1;
    @(negedge sys_clk);
    din_valid = 1'b0;
    din       = 8'($urandom);
    checks++; if (fifo_cnt !== 4'd1) begin errors++; $display("FAIL single_cnt_after_push: got %0d required 1", fifo_cnt); end
    @(negedge sys_clk);
    checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL single_tx_t1: got %b required 1", tx); end
    checks++; if (fifo_cnt !== 4'd0)  begin errors++; $display("FAIL single_cnt_after_pop: got %0d required 0", fifo_cnt); end
    checks++; if (busy_flag !== 1'b1) begin errors++; $display("FAIL single_busy_t1: got %b required 1", busy_flag); end
    @(negedge sys_clk);
    checks++; if (tx !== 1'b0)        begin errors++; $display("FAIL single_tx_t2: got %b required 0", tx); end
    check_frame(8'h03, "single", 1'b1);
    checks++; if (busy_flag !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b required 0", busy_flag); end
    checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL single_tx_end: got %b required 1", tx); end
  endtask

  task automatic test_burst();
    logic [7:0] bb [8];
    int         peak;
    bb = '{8'h03, 8'h0D, 8'h17, 8'h21, 8'h2B, 8'h35, 8'h3F, 8'h49};
    fork
      begin
        peak = 0;
        for (int i = 0; i < 8; i++) begin
          din       = bb[i];
          din_valid = 1'b1;
          @(negedge sys_clk);
          if (i == 1) begin
            checks++;
            if (fifo_cnt !== 4'd1) begin errors++; $display("FAIL burst_push_pop_cnt: got %0d required 1", fifo_cnt); end
          end
          if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
        end
        din_valid = 1'b0;
        checks++;
        if (peak != 7) begin errors++; $display("FAIL burst_peak: got %0d required 7", peak); end
      end
      begin
        for (int i = 0; i < 8; i++) check_frame(bb[i], $sformatf("burst%0d", i), i > 0);
      end
    join
    checks++; if (busy_flag !== 1'b0) begin errors++; $display("FAIL burst_busy_end: got %b required 0", busy_flag); end
    checks++; if (fifo_cnt !== 4'd0)  begin errors++; $display("FAIL burst_cnt_end: got %0d required 0", fifo_cnt); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    fork
      begin
        din = 8'h07; din_valid = 1'b1; @(negedge sys_clk);
        din = 8'h03; @(negedge sys_clk);
        din_valid = 1'b0;
      end
      begin
        check_frame(8'h07, "parity07", 1'b0);
        check_frame(8'h03, "parity03", 1'b1);
      end
    join
  endtask
`endif

  task automatic test_random();
    logic [7:0] rb [3];
    int         gap [3];
    int         w;
    for (int i = 0; i < 3; i++) begin
      rb[i]  = 8'($urandom);
      gap[i] = int'($urandom_range(0, 2 * CPB));
    end
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          for (int g = 0; g < gap[i]; g++) begin
            din = 8'($urandom);
            @(negedge sys_clk);
          end
          din       = rb[i];
          din_valid = 1'b1;
          w = 0;
          while (din_ready !== 1'b1 && w < FRAME) begin
            @(negedge sys_clk);
            w++;
          end
          @(negedge sys_clk);
          din_valid = 1'b0;
          din       = 8'($urandom);
        end
      end
      begin
        for (int i = 0; i < 3; i++) check_frame(rb[i], $sformatf("random%0d", i), 1'b0);
      end
    join
    checks++; if (busy_flag !== 1'b0) begin errors++; $display("FAIL random_busy_end: got %b required 0", busy_flag); end
  endtask

  // Hold din_valid high through a whole frame; model count = accepted pushes - pops,
  // where pops occur one cycle after the first push and then once per frame.
  task automatic test_full();
    logic [7:0] fd0, fd1;
    int         model_cnt, next_pop, bad_rdy_k, bad_cnt_k, got_rdy, got_cnt, exp_rdy_at, exp_cnt_at;
    bit         exp_rdy, pop_now;
    fd0 = 8'($urandom);
    fd1 = ~fd0;
    fork
      begin
        model_cnt = 0;
        next_pop  = 1;
        bad_rdy_k = -1;
        bad_cnt_k = -1;
        got_rdy = 0; got_cnt = 0; exp_rdy_at = 0; exp_cnt_at = 0;
        for (int k = 0; k <= FRAME + 5; k++) begin
          din       = (k == 0) ? fd0 : (k == 1) ? fd1 : 8'($urandom);
          din_valid = 1'b1;
          exp_rdy   = (model_cnt != DEPTH);
          if (din_ready !== exp_rdy && bad_rdy_k < 0) begin
            bad_rdy_k = k; got_rdy = int'(din_ready); exp_rdy_at = int'(exp_rdy);
          end
          pop_now = (k == next_pop) && (model_cnt != 0);
          if (pop_now) next_pop = k + FRAME;
          model_cnt = model_cnt + int'(exp_rdy) - int'(pop_now);
          @(negedge sys_clk);
          if (int'(fifo_cnt) != model_cnt && bad_cnt_k < 0) begin
            bad_cnt_k = k; got_cnt = int'(fifo_cnt); exp_cnt_at = model_cnt;
          end
        end
        din_valid = 1'b0;
        checks++;
        if (bad_rdy_k >= 0) begin
          errors++;
          $display("FAIL full_din_ready: cycle %0d got %0d required %0d", bad_rdy_k, got_rdy, exp_rdy_at);
        end
        checks++;
        if (bad_cnt_k >= 0) begin
          errors++;
          $display("FAIL full_fifo_cnt: cycle %0d got %0d required %0d", bad_cnt_k, got_cnt, exp_cnt_at);
        end
        checks++;
        if (fifo_cnt !== 4'd8) begin errors++; $display("FAIL full_cnt_final: got %0d required 8", fifo_cnt); end
      end
      begin
        check_frame(fd0, "full_f0", 1'b0);
        check_frame(fd1, "full_f1", 1'b1);
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] mb [4];
    bit         quiet;
    mb = '{8'h55, 8'hA1, 8'hB2, 8'hC3};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      din       = mb[i];
      din_valid = 1'b1;
      @(negedge sys_clk);
    end
    din_valid = 1'b0;
    checks++; if (fifo_cnt !== 4'd3) begin errors++; $display("FAIL mid_cnt_before: got %0d required 3", fifo_cnt); end
    repeat (5 * CPB + CPB / 2 - 1) @(negedge sys_clk);
    checks++; if (busy_flag !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b required 1", busy_flag); end
    checks++; if (fifo_cnt !== 4'd3)  begin errors++; $display("FAIL mid_cnt_bit4: got %0d required 3", fifo_cnt); end
    checks++; if (tx !== mb[0][4])    begin errors++; $display("FAIL mid_tx_bit4: got %b required %b", tx, mb[0][4]); end
    rst_n = 1'b0;
    @(negedge sys_clk);
    checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL mid_rst_tx: got %b required 1", tx); end
    checks++; if (fifo_cnt !== 4'd0)  begin errors++; $display("FAIL mid_rst_cnt: got %0d required 0", fifo_cnt); end
    checks++; if (busy_flag !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b required 0", busy_flag); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b required 1", din_ready); end
    @(negedge sys_clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < FRAME + CPB; k++) begin
      @(negedge sys_clk);
      if (tx !== 1'b1 || busy_flag !== 1'b0 || fifo_cnt !== 4'd0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL mid_residual: line activity after reset release, tx=%b busy=%b cnt=%0d required idle", tx, busy_flag, fifo_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_full();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
